// File: rtl/game_pkg.sv
// Shared screen geometry, field widths and palette for the sprite datapaths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: screen size, coordinate/colour widths and types, named 3-bit colours.
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;
  typedef logic [C_W-1:0] c_t;

  localparam c_t C_BLACK   = 3'b000;
  localparam c_t C_BLUE    = 3'b001;
  localparam c_t C_GREEN   = 3'b010;
  localparam c_t C_CYAN    = 3'b011;
  localparam c_t C_RED     = 3'b100;
  localparam c_t C_MAGENTA = 3'b101;
  localparam c_t C_YELLOW  = 3'b110;
  localparam c_t C_WHITE   = 3'b111;

endpackage

// File: rtl/rect_sweeper.sv
// Walks a W x H rectangle one cell per enabled clk, column fastest then row.
// Latency: col/row valid the cycle after start; last is combinational on the final cell.
// Backpressure: holds position while en_i is low; start_i has priority over en_i.
//
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   start_i      synchronous return to cell (0,0)
//   en_i         advance one cell; wraps to (0,0) after the last cell
//   col_o/row_o  current cell
//   last_o       current cell is (W-1, H-1)
module rect_sweeper #(
  parameter  int W  = 4,
  parameter  int H  = 4,
  localparam int CW = (W > 1) ? $clog2(W) : 1,
  localparam int RW = (H > 1) ? $clog2(H) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start_i,
  input  logic          en_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_o
);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == CW'(W - 1));
  assign row_end = (row_q == RW'(H - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else if (start_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en_i) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_end && row_end;

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Round-robin owner of the VGA adapter write port: per grant, erase old rect then draw new one.
// Latency: req to first plot 3 clk; busy 2+W*H clk (no erase) or 2+2*W*H clk (with erase).
// Backpressure: req is a level held until ack; other requesters wait while busy is high.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req                  per-sprite level request
//   req_x/req_y/req_c    packed per-sprite new top-left and colour (requester i in slice i)
//   ack                  one-cycle pulse when requester's draw is complete
//   busy                 high from grant through the completion cycle
//   vga_x/vga_y/vga_c    registered pixel address and colour
//   plot                 registered write enable; low for off-screen pixels
module sprite_draw_arbiter
  import game_pkg::*;
#(
  parameter int       N_REQ     = 3,
  parameter int       SPRITE_W  = 4,
  parameter int       SPRITE_H  = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req,
  input  logic [X_W*N_REQ-1:0]   req_x,
  input  logic [Y_W*N_REQ-1:0]   req_y,
  input  logic [C_W*N_REQ-1:0]   req_c,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_c,
  output logic                   plot
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_ERASE = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // First set bit of r at or above ptr, wrapping; ptr itself if r is empty.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IW-1:0]    ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && r[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Unpack the flat request buses into per-requester arrays.
  x_t req_x_a [N_REQ];
  y_t req_y_a [N_REQ];
  c_t req_c_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_x_a[i] = req_x[X_W*i +: X_W];
    assign req_y_a[i] = req_y[Y_W*i +: Y_W];
    assign req_c_a[i] = req_c[C_W*i +: C_W];
  end

  logic [2:0]      state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_q, rr_d;

  x_t              new_x_q;
  y_t              new_y_q;
  c_t              new_c_q;

  x_t              prev_x_q [N_REQ];
  y_t              prev_y_q [N_REQ];
  logic [N_REQ-1:0] prev_valid_q;

  logic [X_W-1:0]  vga_x_q;
  logic [Y_W-1:0]  vga_y_q;
  logic [C_W-1:0]  vga_c_q;
  logic            plot_q;

  logic [CW-1:0]   sweep_col;
  logic [RW-1:0]   sweep_row;
  logic            sweep_last;
  logic            sweep_start;
  logic            sweep_en;

  logic            need_erase;
  x_t              base_x;
  y_t              base_y;
  logic [X_W:0]    sum_x;
  logic [Y_W:0]    sum_y;
  logic            on_screen;

  assign sweep_start = (state_q == S_LATCH);
  assign sweep_en    = (state_q == S_ERASE) || (state_q == S_DRAW);

  rect_sweeper #(
    .W (SPRITE_W),
    .H (SPRITE_H)
  ) u_sweep (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (sweep_start),
    .en_i    (sweep_en),
    .col_o   (sweep_col),
    .row_o   (sweep_row),
    .last_o  (sweep_last)
  );

  // Evaluated in LATCH: gnt_q is already settled, coordinates are read live
  // from the request bus in the same cycle they get captured.
  assign need_erase = prev_valid_q[gnt_q] &&
                      ((prev_x_q[gnt_q] != req_x_a[gnt_q]) ||
                       (prev_y_q[gnt_q] != req_y_a[gnt_q]));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = rr_pick(req, rr_q);
          state_d = S_LATCH;
        end
      end
      S_LATCH: state_d = need_erase ? S_ERASE : S_DRAW;
      S_ERASE: if (sweep_last) state_d = S_DRAW;
      S_DRAW:  if (sweep_last) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        rr_d    = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Extra top bit on the sums so a rect hanging off the right/bottom edge
  // is clipped rather than wrapping back onto the left/top of the screen.
  always_comb begin
    base_x    = (state_q == S_ERASE) ? prev_x_q[gnt_q] : new_x_q;
    base_y    = (state_q == S_ERASE) ? prev_y_q[gnt_q] : new_y_q;
    sum_x     = {1'b0, base_x} + (X_W+1)'(sweep_col);
    sum_y     = {1'b0, base_y} + (Y_W+1)'(sweep_row);
    on_screen = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      rr_q         <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_c_q      <= '0;
      prev_valid_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        prev_x_q[i] <= '0;
        prev_y_q[i] <= '0;
      end
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_c_q      <= '0;
      plot_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;

      if (state_q == S_LATCH) begin
        new_x_q <= req_x_a[gnt_q];
        new_y_q <= req_y_a[gnt_q];
        new_c_q <= req_c_a[gnt_q];
      end

      // Clipped pixels still take their cycle; only the write enable drops.
      plot_q <= sweep_en && on_screen;
      if (sweep_en) begin
        vga_x_q <= sum_x[X_W-1:0];
        vga_y_q <= sum_y[Y_W-1:0];
        vga_c_q <= (state_q == S_ERASE) ? BG_COLOUR : new_c_q;
      end

      if (state_q == S_DONE) begin
        prev_x_q[gnt_q]     <= new_x_q;
        prev_y_q[gnt_q]     <= new_y_q;
        prev_valid_q[gnt_q] <= 1'b1;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == S_DONE) ack[gnt_q] = 1'b1;
  end

  assign busy  = (state_q != S_IDLE);
  assign vga_x = vga_x_q;
  assign vga_y = vga_y_q;
  assign vga_c = vga_c_q;
  assign plot  = plot_q;

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
module tb_sprite_draw_arbiter;

  localparam int N  = 3;
  localparam int SW = 4;
  localparam int SH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_c;
  logic [2:0]  ack;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_c;
  logic        plot;

  sprite_draw_arbiter #(
    .N_REQ     (N),
    .SPRITE_W  (SW),
    .SPRITE_H  (SH),
    .BG_COLOUR (3'b000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .req_x  (req_x),
    .req_y  (req_y),
    .req_c  (req_c),
    .ack    (ack),
    .busy   (busy),
    .vga_x  (vga_x),
    .vga_y  (vga_y),
    .vga_c  (vga_c),
    .plot   (plot)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An operation is a list of pixels (optional erase rect, then draw rect).
  // Busy lasts 2 + list length cycles; pixel k is visible in busy cycle k+3;
  // ack is in the last busy cycle.
  typedef struct { int x; int y; int c; bit p; } pix_t;
  pix_t m_pix[$];
  int   m_rem = 0;
  int   m_T   = 0;
  int   m_g   = 0;
  int   m_rr  = 0;
  int   m_px[N];
  int   m_py[N];
  bit   m_pv[N];

  // monitor statistics
  int   cnt_busy = 0, cnt_plot = 0, ops_started = 0;
  int   first_x, first_y, first_c, last_x, last_y, last_c;
  int   last_busy = 0, last_plot = 0;
  int   ack_log[$];
  bit   prev_busy = 0;

  int         el, g, nx, ny, nc, aidx;
  pix_t       pe;
  bit         ep, er;
  logic [2:0] exp_ack;

  task automatic add_rect(input int bx, input int by, input int c);
    for (int r = 0; r < SH; r++)
      for (int cc = 0; cc < SW; cc++) begin
        pix_t p;
        p.x = bx + cc;
        p.y = by + r;
        p.c = c;
        p.p = (p.x < 160) && (p.y < 120);
        m_pix.push_back(p);
      end
  endtask

  always @(negedge clk) begin : compare
    if (!resetn) begin
      chk("rst_plot", {31'd0, plot}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_ack",  {29'd0, ack},  0);
      m_rem = 0;
      m_rr  = 0;
      for (int i = 0; i < N; i++) m_pv[i] = 0;
      prev_busy = 0;
    end else begin
      el      = m_T - m_rem + 1;
      exp_ack = (m_rem == 1) ? 3'(1 << m_g) : 3'b000;
      ep      = 0;
      if (m_rem > 0 && el >= 3) begin
        pe = m_pix[el - 3];
        ep = pe.p;
      end
      chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
      chk("ack",  {29'd0, ack},  {29'd0, exp_ack});
      chk("plot", {31'd0, plot}, {31'd0, ep});
      if (ep) begin
        chk("vga_x", {24'd0, vga_x}, pe.x);
        chk("vga_y", {25'd0, vga_y}, pe.y);
        chk("vga_c", {29'd0, vga_c}, pe.c);
      end

      // statistics for the directed checks
      if (busy && !prev_busy) begin
        cnt_busy = 0;
        cnt_plot = 0;
        ops_started++;
      end
      if (busy) cnt_busy++;
      if (plot) begin
        if (cnt_plot == 0) begin
          first_x = vga_x; first_y = vga_y; first_c = vga_c;
        end
        last_x = vga_x; last_y = vga_y; last_c = vga_c;
        cnt_plot++;
      end
      if (ack != 0) begin
        aidx = -1;
        for (int i = N - 1; i >= 0; i--) if (ack[i]) aidx = i;
        ack_log.push_back(aidx);
        last_busy = cnt_busy;
        last_plot = cnt_plot;
      end
      prev_busy = busy;

      // advance the model to the next cycle
      if (m_rem > 0) begin
        m_rem--;
      end else if (req != 0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req[(m_rr + k) % N]) g = (m_rr + k) % N;
        nx = int'((req_x >> (8 * g)) & 24'hff);
        ny = int'((req_y >> (7 * g)) & 21'h7f);
        nc = int'((req_c >> (3 * g)) & 9'h7);
        er = m_pv[g] && (m_px[g] != nx || m_py[g] != ny);
        m_pix.delete();
        if (er) add_rect(m_px[g], m_py[g], 0);
        add_rect(nx, ny, nc);
        m_T   = 2 + m_pix.size();
        m_rem = m_T;
        m_g   = g;
        m_px[g] = nx;
        m_py[g] = ny;
        m_pv[g] = 1;
        m_rr  = (g + 1) % N;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int log_at(input int i);
    return (i < ack_log.size()) ? ack_log[i] : -1;
  endfunction

  task automatic set_pos(input int i, input int x, input int y, input int c);
    req_x[8*i +: 8] = 8'(x);
    req_y[7*i +: 7] = 7'(y);
    req_c[3*i +: 3] = 3'(c);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    req    = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Runs until n_new more acks. A requester's bit drops on its ack unless held;
  // rearm0 re-raises req[0] whenever the arbiter is busy with someone else.
  task automatic run_ops(input int n_new, input logic [2:0] hold, input bit rearm0,
                         input int budget);
    int start, seen;
    start = ack_log.size();
    seen  = start;
    for (int cyc = 0; cyc < budget && ack_log.size() < start + n_new; cyc++) begin
      @(posedge clk); #1;
      while (seen < ack_log.size()) begin
        if (ack_log[seen] >= 0 && !hold[ack_log[seen]]) req[ack_log[seen]] = 1'b0;
        seen++;
      end
      if (rearm0 && !req[0] && busy) req[0] = 1'b1;
    end
    chk("ops_completed", ack_log.size(), start + n_new);
    req = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, n_before;
    bit hit;
    resetn = 1'b0;
    req    = '0;
    req_x  = '0;
    req_y  = '0;
    req_c  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_plot",  {31'd0, plot},  0);
    chk("reset_busy",  {31'd0, busy},  0);
    chk("reset_ack",   {29'd0, ack},   0);
    chk("reset_vga_x", {24'd0, vga_x}, 0);
    chk("reset_vga_y", {25'd0, vga_y}, 0);
    chk("reset_vga_c", {29'd0, vga_c}, 0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: first draw, no erase
    set_pos(0, 10, 116, 2);
    base = ack_log.size();
    req  = 3'b001;
    run_ops(1, 3'b000, 0, 100);
    chk("t1_ack_idx", log_at(base), 0);
    chk("t1_busy",    last_busy, 18);
    chk("t1_plots",   last_plot, 16);
    chk("t1_first_x", first_x, 10);
    chk("t1_first_y", first_y, 116);
    chk("t1_first_c", first_c, 2);
    chk("t1_last_x",  last_x, 13);
    chk("t1_last_y",  last_y, 119);

    // 2: move requester 0 -> erase old rect, draw new
    set_pos(0, 12, 116, 2);
    req = 3'b001;
    run_ops(1, 3'b000, 0, 100);
    chk("t2_busy",    last_busy, 34);
    chk("t2_plots",   last_plot, 32);
    chk("t2_first_x", first_x, 10);
    chk("t2_first_c", first_c, 0);
    chk("t2_last_x",  last_x, 15);
    chk("t2_last_y",  last_y, 119);
    chk("t2_last_c",  last_c, 2);

    // 4: clipped corner; req dropped once granted, op still completes
    set_pos(1, 158, 118, 7);
    base = ack_log.size();
    req  = 3'b010;
    hit  = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge clk); #1;
      hit = busy;
    end
    chk("t4_granted", {31'd0, hit}, 1);
    req = 3'b000;
    run_ops(1, 3'b000, 0, 100);
    chk("t4_ack_idx", log_at(base), 1);
    chk("t4_busy",    last_busy, 18);
    chk("t4_plots",   last_plot, 4);
    chk("t4_first_x", first_x, 158);
    chk("t4_first_y", first_y, 118);
    chk("t4_last_x",  last_x, 159);
    chk("t4_last_y",  last_y, 119);

    // 3: all three at once after reset -> 0,1,2
    do_reset();
    set_pos(1, 40, 20, 4);
    set_pos(2, 80, 60, 1);
    base = ack_log.size();
    req  = 3'b111;
    run_ops(3, 3'b000, 0, 300);
    chk("t3_order0", log_at(base),     0);
    chk("t3_order1", log_at(base + 1), 1);
    chk("t3_order2", log_at(base + 2), 2);

    // 5: reset during draw pixel 7 of an erase+draw op
    set_pos(0, 20, 30, 3);
    base     = ops_started;
    n_before = ack_log.size();
    req      = 3'b001;
    hit      = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #1;
      hit = (ops_started > base) && (cnt_plot >= 23);
    end
    chk("t5_reached_pixel7", {31'd0, hit}, 1);
    resetn = 1'b0;
    req    = '0;
    #1;
    chk("t5_plot_now", {31'd0, plot}, 0);
    chk("t5_busy_now", {31'd0, busy}, 0);
    chk("t5_ack_now",  {29'd0, ack},  0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    chk("t5_no_ack", ack_log.size(), n_before);
    @(posedge clk); #1;
    req = 3'b001;
    run_ops(1, 3'b000, 0, 100);
    chk("t5_redraw_busy",  last_busy, 18);
    chk("t5_redraw_plots", last_plot, 16);

    // 6: req[2] held, req[0] re-raised -> 2,0,2,0
    base = ack_log.size();
    req  = 3'b100;
    run_ops(4, 3'b100, 1, 400);
    chk("t6_seq0", log_at(base),     2);
    chk("t6_seq1", log_at(base + 1), 0);
    chk("t6_seq2", log_at(base + 2), 2);
    chk("t6_seq3", log_at(base + 3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
